// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// A WAIT timeout turns a hung memory into a synthetic error response.
//
// state | meaning
// IDLE  | scan requesters from rr pointer, latch payload of the winner
// ISSUE | mem_valid pulse, timeout counter cleared
// WAIT  | await mem_ready or timeout, capture response
// RESP  | req_ready pulse to grantee, advance rr pointer
module mem_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_wr_rd,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       req_error,
  output logic                       mem_valid,
  output logic                       mem_wr_rd,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_error,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  to_cnt;
  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;
  logic              timeout_hit;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]  ptr_nx;
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[wrap_idx(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign grant_oh    = NUM_REQ'(1) << grant_id;
  assign ptr_nx      = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_found) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (mem_ready || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      to_cnt    <= '0;
      req_ready <= '0;
      req_rdata <= '0;
      req_error <= 1'b0;
      mem_valid <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      mem_valid <= 1'b0;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            grant_id  <= gnt_idx;
            mem_wr_rd <= req_wr_rd[gnt_idx];
            mem_addr  <= addr_arr[gnt_idx];
            mem_wdata <= wdata_arr[gnt_idx];
            mem_valid <= 1'b1;
          end
        end
        ISSUE: to_cnt <= '0;
        WAIT: begin
          if (mem_ready) begin
            req_rdata <= mem_rdata;
            req_error <= mem_error;
            req_ready <= grant_oh;
          end else if (timeout_hit) begin
            req_rdata <= '0;
            req_error <= 1'b1;
            req_ready <= grant_oh;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP:    rr_ptr <= ptr_nx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: behavioural memory, expected responses
// queued at stimulus time and compared as req_ready pulses appear.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr_rd = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic            req_error;
  logic            mem_valid;
  logic            mem_wr_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_error = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  mem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_error(req_error),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; bit wr; logic [31:0] rdata; bit err;} exp_t;
  typedef struct {int cyc; logic [N-1:0] ready; logic [1:0] gid; logic [31:0] rdata; logic err;} rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_log[$];
  int          mv_cyc[$];
  logic [31:0] ref_mem [int];
  int          rsp_rd = 0;
  int          reps [N];
  int          checks = 0;
  int          errors = 0;

  // Behavioural memory: answers mem_delay cycles after the mem_valid cycle.
  logic [31:0] mem_arr [1024];
  int          mem_delay = 1;
  int          pend_cnt = 0;
  bit          pend_wr = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_wdata = '0;
  bit          prev_mv = 1'b0;
  int          mv_double = 0;

  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_ready = 1'b1;
        if (pend_addr >= 1024) begin
          mem_error = 1'b1;
          mem_rdata = 32'hBADBAD00;
        end else if (pend_wr) mem_arr[pend_addr[9:0]] = pend_wdata;
        else mem_rdata = mem_arr[pend_addr[9:0]];
      end
    end
    if (mem_valid) begin
      if (prev_mv) mv_double++;
      pend_cnt   = mem_delay;
      pend_wr    = mem_wr_rd;
      pend_addr  = mem_addr;
      pend_wdata = mem_wdata;
      mv_cyc.push_back(cyc);
    end
    prev_mv = mem_valid;
  end

  always @(negedge clk) begin
    rsp_t r;
    if (req_ready != '0) begin
      r.cyc = cyc; r.ready = req_ready; r.gid = grant_id; r.rdata = req_rdata; r.err = req_error;
      rsp_log.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] data, input int n);
    req_wr_rd[id]          = wr;
    req_addr[id*AW +: AW]  = addr;
    req_wdata[id*DW +: DW] = data;
    req_valid[id]          = 1'b1;
    reps[id]               = n;
  endtask

  task automatic expect_txn(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.id = id; e.wr = wr; e.err = (addr >= 1024); e.rdata = '0;
    if (e.err) e.rdata = 32'hBADBAD00;
    else if (wr) ref_mem[int'(addr)] = data;
    else e.rdata = ref_mem[int'(addr)];
    exp_q.push_back(e);
  endtask

  task automatic drain();
    rsp_t r;
    exp_t e;
    while (rsp_rd < rsp_log.size()) begin
      r = rsp_log[rsp_rd];
      rsp_rd++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(r.ready), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ready_onehot", 64'(r.ready), 64'(N'(1) << e.id));
        check("grant_id", 64'(r.gid), 64'(e.id));
        check("req_error", 64'(r.err), 64'(e.err));
        if (!e.wr) check("req_rdata", 64'(r.rdata), 64'(e.rdata));
      end
    end
  endtask

  task automatic service(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          if (reps[i] > 0) reps[i]--;
          if (reps[i] == 0) req_valid[i] = 1'b0;
        end
      end
      drain();
    end
    check("service_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
    check({tag, "_req_error"}, 64'(req_error), 64'd0);
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_mem_wr_rd"}, 64'(mem_wr_rd), 64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_grant_id"},  64'(grant_id),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    int t0, mvb, rb, n;
    exp_t e;
    for (int i = 0; i < N; i++) reps[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    // 1: write then read 0x10 by requester 0, with latency
    t0 = cyc; mvb = mv_cyc.size(); rb = rsp_log.size();
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 1);
    expect_txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    service(20);
    check("t1_wr_mv_lat", 64'(mv_cyc[mvb] - t0), 64'd1);
    check("t1_wr_rdy_lat", 64'(rsp_log[rb].cyc - t0), 64'd3);
    @(negedge clk); #1;
    t0 = cyc; mvb = mv_cyc.size(); rb = rsp_log.size();
    drive(0, 1'b0, 32'h10, 32'h0, 1);
    expect_txn(0, 1'b0, 32'h10, 32'h0);
    service(20);
    check("t1_rd_mv_lat", 64'(mv_cyc[mvb] - t0), 64'd1);
    check("t1_rd_rdy_lat", 64'(rsp_log[rb].cyc - t0), 64'd3);

    // 2: requesters 1..3 write, then all four read simultaneously
    @(negedge clk); #1;
    for (int i = 1; i < N; i++) begin
      drive(i, 1'b1, 32'h100 + i, 32'hA5000000 + i, 1);
      expect_txn(i, 1'b1, 32'h100 + i, 32'hA5000000 + i);
    end
    service(40);
    @(negedge clk); #1;
    rb = rsp_log.size();
    drive(0, 1'b0, 32'h10, 32'h0, 1);
    expect_txn(0, 1'b0, 32'h10, 32'h0);
    for (int i = 1; i < N; i++) begin
      drive(i, 1'b0, 32'h100 + i, 32'h0, 1);
      expect_txn(i, 1'b0, 32'h100 + i, 32'h0);
    end
    service(40);
    for (int k = 1; k < N; k++) check("t2_spacing", 64'(rsp_log[rb+k].cyc - rsp_log[rb+k-1].cyc), 64'd4);

    // 3: requester 1 back-to-back against requester 2 -> 1,2,1,2,1
    @(negedge clk); #1;
    drive(1, 1'b0, 32'h101, 32'h0, 3);
    drive(2, 1'b0, 32'h102, 32'h0, 2);
    expect_txn(1, 1'b0, 32'h101, 32'h0);
    expect_txn(2, 1'b0, 32'h102, 32'h0);
    expect_txn(1, 1'b0, 32'h101, 32'h0);
    expect_txn(2, 1'b0, 32'h102, 32'h0);
    expect_txn(1, 1'b0, 32'h101, 32'h0);
    service(60);

    // 4: out-of-range write and read by requester 3, then memory still intact
    @(negedge clk); #1;
    drive(3, 1'b1, 32'h400, 32'h12345678, 1);
    expect_txn(3, 1'b1, 32'h400, 32'h12345678);
    service(20);
    @(negedge clk); #1;
    drive(3, 1'b0, 32'h400, 32'h0, 1);
    expect_txn(3, 1'b0, 32'h400, 32'h0);
    service(20);
    @(negedge clk); #1;
    drive(0, 1'b0, 32'h10, 32'h0, 1);
    expect_txn(0, 1'b0, 32'h10, 32'h0);
    service(20);

    // 5: memory answers too late -> synthetic error, late ready ignored
    @(negedge clk); #1;
    mem_delay = 20;
    mvb = mv_cyc.size(); rb = rsp_log.size();
    drive(0, 1'b0, 32'h10, 32'h0, 1);
    e.id = 0; e.wr = 1'b0; e.rdata = '0; e.err = 1'b1;
    exp_q.push_back(e);
    service(60);
    check("t5_timeout_lat", 64'(rsp_log[rb].cyc - mv_cyc[mvb]), 64'(TO + 1));
    repeat (25) @(negedge clk);
    #1 drain();
    check("t5_idle_after", 64'(busy), 64'd0);
    check("t5_no_late_rsp", 64'(rsp_log.size()), 64'(rb + 1));
    mem_delay = 1;

    // 6: reset mid-WAIT with requester 2 granted; pointer must restart at 0
    drive(2, 1'b0, 32'h102, 32'h0, 1);
    expect_txn(2, 1'b0, 32'h102, 32'h0);
    service(20);
    @(negedge clk); #1;
    mem_delay = 5;
    rb = rsp_log.size();
    drive(2, 1'b0, 32'h10, 32'h0, 1);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!mem_valid && n < 10);
    check("t6_issue_seen", 64'(mem_valid), 64'd1);
    @(negedge clk); #1;
    check("t6_busy_in_wait", 64'(busy), 64'd1);
    check("t6_grant_in_wait", 64'(grant_id), 64'd2);
    rst = 1'b1;
    @(negedge clk); #1;
    check_zero("t6_reset");
    check("t6_no_rsp", 64'(rsp_log.size()), 64'(rb));
    mem_delay = 1;
    drive(3, 1'b0, 32'h103, 32'h0, 1);
    expect_txn(2, 1'b0, 32'h10, 32'h0);
    expect_txn(3, 1'b0, 32'h103, 32'h0);
    rst = 1'b0;
    service(40);

    repeat (10) @(negedge clk);
    #1 drain();
    check("mem_valid_single", 64'(mv_double), 64'd0);
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin arbiter that shares one single-port 1024x32 memory between NUM_REQ requesters.
- Accepts per-requester read/write requests and grants one at a time.
- Drives the memory's valid/wr_rd/addr/wdata handshake, waits for the memory's ready pulse, and returns rdata/error to the granted requester.
- Sits between bus-side masters (DMA, CPU port, test engine) and the memory block. Adds a response timeout so a hung memory cannot lock the system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width on both sides (memory flags addr >= 1024 as error)
DATA_W, 32, data width
TIMEOUT_CYC, 16, max cycles in WAIT before a synthetic error response (>= 2)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request; held high until its req_ready pulse
req_wr_rd  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed likewise
req_ready  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester
req_rdata  out  DATA_W  shared read data, qualified by req_ready
req_error  out  1  shared error flag, qualified by req_ready
mem_valid  out  1  1-cycle request pulse to memory
mem_wr_rd  out  1  latched wr_rd
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_ready  in  1  memory completion pulse
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_error  in  1  memory error, valid with mem_ready
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at posedge) has priority over everything, including mid-transaction. After reset:
  - state=IDLE, rr pointer=0.
  - All outputs 0: req_ready, req_rdata, req_error, mem_valid, mem_wr_rd, mem_addr, mem_wdata, grant_id, busy.
  - Any in-flight transaction is abandoned, with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, with any req_valid high:
  - Grant the first valid requester searching from the rr pointer upward, wrapping modulo NUM_REQ.
  - Latch that requester's wr_rd/addr/wdata into mem_wr_rd/mem_addr/mem_wdata.
  - Set grant_id and go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE: mem_valid=1 for exactly this one cycle. Clear the timeout counter and go to WAIT.
- WAIT: mem_valid=0, and mem_addr/mem_wdata/mem_wr_rd stay stable.
  - On mem_ready=1: capture mem_rdata and mem_error, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYC-1 without mem_ready, capture rdata=0 and error=1, then go to RESP.
- RESP:
  - req_ready[grant_id]=1 for this one cycle, with captured rdata/error on req_rdata/req_error.
  - rr pointer := (grant_id+1) mod NUM_REQ, then go to IDLE.
  - req_rdata/req_error hold their values until the next RESP. req_rdata is don't-care for writes; memory-side rdata is passed through as captured.
- Latency: request first seen in IDLE at cycle T:
  - mem_valid at T+1, mem_ready nominally at T+2, req_ready at T+3.
  - Minimum 4 cycles per transaction back-to-back (RESP -> IDLE -> ISSUE ...).
- Fairness: a requester is not re-granted while another valid requester lies between it and the pointer. The worst-case wait is NUM_REQ-1 transactions.
- Requesters must hold valid and payload until req_ready. Payload is latched at grant, so changes after grant have no effect. If valid is dropped after grant, the transaction still completes and the req_ready pulse is still issued.
- Requester i sees req_ready in RESP and may reassert a new request immediately. It is seen in the following IDLE but ranks behind the others.
- A mem_ready arriving in IDLE, ISSUE or RESP (spurious or late after a timeout) is ignored.
- Out-of-range addresses are forwarded unchanged. The memory's error is returned as req_error=1.

Test Plan:
1. Reset, then requester 0 writes addr 0x10 data 0xDEADBEEF, then reads 0x10 -> mem_valid 1 cycle after grant; read returns req_rdata=0xDEADBEEF, req_error=0, req_ready[0] pulse 3 cycles after valid.
2. All 4 requesters valid simultaneously, each reading a distinct address -> grants in order 0,1,2,3; grant_id 0..3; each req_ready one-hot 1-cycle; 4-cycle spacing.
3. Requester 1 keeps requesting back-to-back while requester 2 stays valid -> grants alternate 1,2,1,2; never 1,1 while 2 waits.
4. Requester 3 reads addr 0x400 (1024) -> req_error=1, req_ready[3] pulse; memory contents unchanged.
5. Memory model holds mem_ready low -> after TIMEOUT_CYC=16 cycles in WAIT: req_ready pulses with req_error=1, req_rdata=0; arbiter returns to IDLE; a late mem_ready is ignored.
6. Assert rst in WAIT with requester 2 granted -> next cycle state IDLE, all outputs 0, no req_ready; requester 2 (still valid) re-granted first after rst deasserts, pointer=0 scan order.
